pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake and 2-entry skid
//  buffer; next-generation replacement for the fixed 32-bit IF/ID latch.
//  Carries an arbitrary payload (e.g. {pc4, inst}) between any two CPU pipeline stages.
//  Supports back-pressure without a combinational ready path, flush to bubble,
//  and stall/flush performance counters.
// PARAMETERS
//  WIDTH      64   payload width in bits
//  BUBBLE_VAL 0    payload driven on out_data when the stage holds no valid entry (NOP)
//  CNT_W      16   width of the saturating stall/flush counters
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous reset, active-high
//  in_valid   in   1      upstream entry valid
//  in_ready   out  1      stage can accept an entry; registered (no in->out comb path)
//  in_data    in   WIDTH  upstream payload
//  flush      in   1      discard all held entries (branch/jump redirect)
//  out_valid  out  1      out_data holds a valid entry
//  out_ready  in   1      downstream accepts the entry this cycle
//  out_data   out  WIDTH  payload to downstream; BUBBLE_VAL when out_valid=0
//  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
//  flush_cnt  out  CNT_W  cycles with flush=1, saturating
// BEHAVIOUR
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//    Upstream must hold in_data stable while in_valid=1 and in_ready=0.
//  - Storage: main register (drives out_data) + skid register. FSM states:
//    EMPTY (nothing held), FULL (main valid), SKID (main and skid valid).
//  - Outputs by state: in_ready=1 in EMPTY/FULL, 0 in SKID; out_valid=0 in EMPTY,
//    1 in FULL/SKID. Both are decoded from state flops only.
//  - Transitions (no flush):
//    EMPTY: in_fire -> FULL, main<=in_data; else stay.
//    FULL : in_fire & out_fire  -> FULL, main<=in_data.
//           in_fire & !out_fire -> SKID, skid<=in_data.
//           !in_fire & out_fire -> EMPTY.  neither -> stay.
//    SKID : out_fire -> FULL, main<=skid; else stay. in_fire impossible.
//  - Latency 1 cycle in_fire->out_valid from EMPTY; sustained throughput 1 entry/cycle
//    with out_ready=1. Entries leave in arrival order; none dropped or duplicated.
//  - flush=1 (priority over all transitions): next state EMPTY, both entries
//    invalidated. An in_fire in the flush cycle completes its handshake but the
//    entry is discarded. out_fire in the flush cycle is honoured downstream as usual.
//  - reset=1 (priority over flush): state EMPTY, out_valid=0, in_ready=1,
//    out_data=BUBBLE_VAL, skid cleared to BUBBLE_VAL, stall_cnt=0, flush_cnt=0.
//    Reset mid-transfer discards all held entries.
//  - out_data = BUBBLE_VAL whenever state is EMPTY (including after flush).
//  - stall_cnt +1 on each cycle out_valid & !out_ready; flush_cnt +1 on each flush
//    cycle (including when already EMPTY); both hold at 2^CNT_W-1, never wrap.
//    Counters update independently of state; flush and stall may count same cycle.
// TESTING
//  1. Reset: reset=1 two cycles -> out_valid=0, in_ready=1, out_data=0, counters 0.
//  2. Streaming: out_ready=1, in_data=1..8 back-to-back -> out_data 1..8 each one
//     cycle after acceptance, in_ready stays 1, stall_cnt=0.
//  3. Back-pressure: send A,B with out_ready=0 -> state SKID, in_ready=0, out_data=A
//     held, stall_cnt counts; raise out_ready -> A then B emerge, in_ready returns 1.
//  4. Flush in SKID with in_valid=1 (C) -> next cycle out_valid=0, out_data=BUBBLE_VAL,
//     C never appears at output, flush_cnt=1.
//  5. Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15.
//  6. Reset asserted in FULL with simultaneous flush and in_fire -> next cycle EMPTY,
//     flush_cnt=0, no entry emitted.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline register with valid/ready handshake and a
// 2-entry skid buffer, flush-to-bubble and saturating stall/flush counters.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready comes from state flops)
//   in_data               upstream payload
//   flush                 discard every held entry, return to bubble
//   out_valid/out_ready   downstream handshake (out_valid from state flops)
//   out_data              payload to downstream, BUBBLE_VAL when empty
//   stall_cnt             cycles with out_valid=1 and out_ready=0
//   flush_cnt             cycles with flush=1
module pipe_skid_stage #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int               CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs decode straight from the state flops, so neither
    // ready nor valid has a combinational path from the other side.
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // main_q is forced to BUBBLE_VAL on every path into EMPTY, so it can
    // drive out_data directly with no output mux.
    assign out_data  = main_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= FULL;
                        main_q <= in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= SKID;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                        main_q <= BUBBLE_VAL;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state  <= FULL;
                        main_q <= skid_q;
                        skid_q <= BUBBLE_VAL;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_VAL;
                    skid_q <= BUBBLE_VAL;
                end
            endcase
        end
    end

    // Counters run independently of the FSM and stick at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
